// File: rtl/mil_bc_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mil_bc_sched_pkg
// Purpose  : Shared types and constants for the 1553 bus-controller sequencer
// Revision : 1.0 - initial release
// ============================================================================
package mil_bc_sched_pkg;

    // Sequencer states. S_SEND keeps its encoding slot but is never entered,
    // because the command word is handed to the transmitter directly from IDLE.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_ARM   = 3'd2,
        S_XMIT  = 3'd3,
        S_FETCH = 3'd4,
        S_RESP  = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    // Bit positions inside err = {tx_fault, bad_sync, timeout}
    localparam int ERR_TO   = 0;
    localparam int ERR_SYNC = 1;
    localparam int ERR_TX   = 2;

    // Default interval lengths in clk cycles (50 MHz)
    localparam int TO_CYC_DEF  = 1000;
    localparam int GAP_CYC_DEF = 200;
    localparam int ARM_CYC_DEF = 16;

    // Interval timer width
    localparam int TMR_W = 16;

    // Preset for an interval of N cycles: the timer is loaded on the entering
    // edge and flags terminal count in the N-th cycle of the state.
    function automatic logic [TMR_W-1:0] tmr_preset(input int cycles);
        return TMR_W'(cycles - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mil_bc_sched_timer.sv
`default_nettype none
// ============================================================================
// Module   : mil_bc_timer
// Purpose  : Loadable down-counter with terminal-count flag, shared by the
//            ARM, RESP and GAP intervals of the sequencer
// Revision : 1.0 - initial release
// ============================================================================
module mil_bc_timer
    import mil_bc_sched_pkg::*;
(
    input  logic             clk,
    input  logic             R,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             tc
);

    logic [TMR_W-1:0] cnt;

    // Count down to zero and hold there; a load always takes priority
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mil_bc_sched.sv
`default_nettype none
// ============================================================================
// Module   : mil_bc_sched
// Purpose  : Bus-controller message sequencer: sends a command word plus up
//            to 15 data words through the Manchester transmitter, then waits
//            (with timeout) for the remote terminal status word
// Revision : 1.0 - initial release
// ============================================================================
module mil_bc_sched
    import mil_bc_sched_pkg::*;
#(
    parameter int TO_CYC  = TO_CYC_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF,
    parameter int ARM_CYC = ARM_CYC_DEF
) (
    input  logic        clk,
    input  logic        R,
    input  logic        start,
    input  logic [15:0] cw_in,
    input  logic [3:0]  n_dw,
    output logic        dw_req,
    input  logic        dw_vld,
    input  logic [15:0] dw_in,
    output logic        txen,
    output logic [15:0] dat,
    input  logic        en_tx,
    input  logic        ok_rx,
    input  logic        rx_cw_dw,
    input  logic [15:0] rx_dat,
    output logic        busy,
    output logic        done,
    output logic [15:0] status,
    output logic [2:0]  err
);

    state_t           state;
    logic [3:0]       n_dw_q;
    logic [3:0]       dw_cnt;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_tc;

    mil_bc_timer u_timer (
        .clk      (clk),
        .R        (R),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // Reload the shared timer on the edge that enters a timed state
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if ((state == S_IDLE && start) || (state == S_FETCH && dw_vld)) begin
            tmr_load = 1'b1;
            tmr_val  = tmr_preset(ARM_CYC);
        end else if (state == S_XMIT && !en_tx && dw_cnt == n_dw_q) begin
            tmr_load = 1'b1;
            tmr_val  = tmr_preset(TO_CYC);
        end else if ((state == S_ARM && !en_tx && tmr_tc) ||
                     (state == S_RESP && (ok_rx || tmr_tc))) begin
            tmr_load = 1'b1;
            tmr_val  = tmr_preset(GAP_CYC);
        end
    end

    // Message sequencer with registered strobes and outputs
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state  <= S_IDLE;
            n_dw_q <= '0;
            dw_cnt <= '0;
            txen   <= 1'b0;
            dw_req <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
            dat    <= '0;
            status <= '0;
            err    <= '0;
        end else begin
            txen   <= 1'b0;
            dw_req <= 1'b0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dat    <= cw_in;
                        n_dw_q <= n_dw;
                        dw_cnt <= '0;
                        err    <= '0;
                        txen   <= 1'b1;
                        busy   <= 1'b1;
                        state  <= S_ARM;
                    end
                end
                S_ARM: begin
                    // en_tx seen in the last allowed cycle still counts as armed
                    if (en_tx) begin
                        state <= S_XMIT;
                    end else if (tmr_tc) begin
                        err[ERR_TX] <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_GAP;
                    end
                end
                S_XMIT: begin
                    // en_tx was high on entry, so a low level marks its falling edge
                    if (!en_tx) begin
                        if (dw_cnt < n_dw_q) begin
                            dw_req <= 1'b1;
                            state  <= S_FETCH;
                        end else begin
                            state <= S_RESP;
                        end
                    end
                end
                S_FETCH: begin
                    if (dw_vld) begin
                        dat    <= dw_in;
                        dw_cnt <= dw_cnt + 1'b1;
                        txen   <= 1'b1;
                        state  <= S_ARM;
                    end
                end
                S_RESP: begin
                    // A reply arriving in the timeout cycle takes precedence
                    if (ok_rx) begin
                        if (rx_cw_dw) begin
                            status <= rx_dat;
                        end else begin
                            err[ERR_SYNC] <= 1'b1;
                        end
                        done  <= 1'b1;
                        state <= S_GAP;
                    end else if (tmr_tc) begin
                        err[ERR_TO] <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (tmr_tc) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mil_bc_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mil_bc_sched
// Purpose  : Self-checking bench for mil_bc_sched: table of message scenarios
//            driven through a transmitter/host/terminal model, plus hand-written
//            reset and robustness sequences
// Revision : 1.0 - initial release
// ============================================================================
module tb_mil_bc_sched;

    localparam int TO       = 1000;
    localparam int GAP      = 200;
    localparam int ARM      = 16;
    localparam int ARM_LAT  = 2;    // txen to en_tx rise in the transmitter model
    localparam int WORD_LEN = 12;   // en_tx high time per word in the model
    localparam int BUDGET   = 3000;

    localparam int M_NONE = 0;
    localparam int M_GOOD = 1;
    localparam int M_BAD  = 2;

    typedef struct {
        logic [15:0] cw;
        int          n;
        int          lat;
        int          mode;
        int          delay;
        logic [15:0] rdata;
        logic [15:0] dw_base;
        bit          dead;
        bit          poke;
        logic [2:0]  exp_err;
        logic [15:0] exp_status;
    } vec_t;

    logic        clk = 1'b0;
    logic        R = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cw_in = '0;
    logic [3:0]  n_dw = '0;
    logic        dw_req;
    logic        dw_vld = 1'b0;
    logic [15:0] dw_in = '0;
    logic        txen;
    logic [15:0] dat;
    logic        en_tx = 1'b0;
    logic        ok_rx = 1'b0;
    logic        rx_cw_dw = 1'b0;
    logic [15:0] rx_dat = '0;
    logic        busy;
    logic        done;
    logic [15:0] status;
    logic [2:0]  err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    vec_t vecs[7];

    mil_bc_sched #(.TO_CYC(TO), .GAP_CYC(GAP), .ARM_CYC(ARM)) dut (
        .clk      (clk),
        .R        (R),
        .start    (start),
        .cw_in    (cw_in),
        .n_dw     (n_dw),
        .dw_req   (dw_req),
        .dw_vld   (dw_vld),
        .dw_in    (dw_in),
        .txen     (txen),
        .dat      (dat),
        .en_tx    (en_tx),
        .ok_rx    (ok_rx),
        .rx_cw_dw (rx_cw_dw),
        .rx_dat   (rx_dat),
        .busy     (busy),
        .done     (done),
        .status   (status),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One complete message: start, transmitter/host/terminal model, checks
    task automatic run_msg(input vec_t v);
        int          t0;
        int          txen_n = 0;
        int          dwreq_n = 0;
        int          done_n = 0;
        int          en_start = -1;
        int          en_end = -1;
        int          fall = -1;
        int          fall_last = -1;
        int          req_cyc = -1;
        int          vld_cyc = -1;
        int          reply_cyc = -1;
        int          done_cyc = -1;
        int          last_txen = -1;
        int          exp_done;
        int          extra = 0;
        bit          finished = 1'b0;
        logic [15:0] exp_word;

        @(negedge clk);
        start = 1'b1;
        cw_in = v.cw;
        n_dw  = 4'(v.n);
        t0    = cyc;
        for (int i = 0; i < BUDGET && !finished; i++) begin
            @(negedge clk);
            start    = 1'b0;
            dw_vld   = 1'b0;
            ok_rx    = 1'b0;
            rx_cw_dw = 1'b0;

            if (txen) begin
                exp_word = (txen_n == 0) ? v.cw : v.dw_base + 16'(txen_n - 1);
                chk("txen_dat", {16'h0, dat}, {16'h0, exp_word});
                if (txen_n == 0) begin
                    chk("txen_after_start", cyc, t0 + 1);
                    chk("busy_at_txen", {31'h0, busy}, 1);
                end else begin
                    chk("txen_after_dw_vld", cyc, vld_cyc + 1);
                end
                txen_n++;
                last_txen = cyc;
                if (!v.dead) begin
                    en_start = cyc + ARM_LAT;
                    en_end   = en_start + WORD_LEN - 1;
                end
            end
            if (dw_req) begin
                chk("dw_req_after_fall", cyc, fall + 1);
                dwreq_n++;
                req_cyc = cyc;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
                if (v.dead)
                    exp_done = last_txen + ARM;
                else if (v.mode == M_NONE)
                    exp_done = fall_last + 1 + TO;
                else
                    exp_done = reply_cyc + 1;
                chk("done_cycle", cyc, exp_done);
                chk("err", {29'h0, err}, {29'h0, v.exp_err});
                chk("status", {16'h0, status}, {16'h0, v.exp_status});
            end
            if (done_cyc >= 0 && !busy) begin
                chk("busy_fall", cyc, done_cyc + GAP);
                finished = 1'b1;
            end

            // Transmitter model
            en_tx = (en_start >= 0 && cyc >= en_start && cyc <= en_end);
            if (en_end >= 0 && cyc == en_end + 1) begin
                fall = cyc;
                if (txen_n == v.n + 1) begin
                    fall_last = cyc;
                    if (v.mode != M_NONE) reply_cyc = cyc + v.delay;
                end
            end
            // Own-word echo on the loopback while transmitting
            if (cyc == en_end) begin
                ok_rx    = 1'b1;
                rx_cw_dw = 1'b1;
                rx_dat   = 16'hEEEE;
            end
            // Host model
            if (req_cyc >= 0 && cyc == req_cyc + v.lat) begin
                dw_vld  = 1'b1;
                dw_in   = v.dw_base + 16'(dwreq_n - 1);
                vld_cyc = cyc;
            end
            // Remote terminal model
            if (reply_cyc >= 0 && cyc == reply_cyc) begin
                ok_rx    = 1'b1;
                rx_cw_dw = (v.mode == M_GOOD);
                rx_dat   = v.rdata;
            end
            // Stray requests while the message is in progress
            if (v.poke && (cyc == t0 + 6 || (done_cyc >= 0 && cyc == done_cyc + 3))) begin
                start = 1'b1;
                cw_in = 16'hFFFF;
                n_dw  = 4'd0;
            end
        end
        en_tx    = 1'b0;
        ok_rx    = 1'b0;
        rx_cw_dw = 1'b0;
        start    = 1'b0;

        chk("msg_completed", {31'h0, finished}, 1);
        chk("txen_count", txen_n, v.dead ? 1 : v.n + 1);
        chk("dw_req_count", dwreq_n, v.dead ? 0 : v.n);
        chk("done_count", done_n, 1);
        repeat (10) begin
            @(negedge clk);
            if (txen || busy) extra++;
        end
        chk("idle_after_gap", extra, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_txen"},   {31'h0, txen},   0);
        chk({tag, "_dw_req"}, {31'h0, dw_req}, 0);
        chk({tag, "_done"},   {31'h0, done},   0);
        chk({tag, "_busy"},   {31'h0, busy},   0);
        chk({tag, "_dat"},    {16'h0, dat},    0);
        chk({tag, "_status"}, {16'h0, status}, 0);
        chk({tag, "_err"},    {29'h0, err},    0);
    endtask

    initial begin
        //         cw        n  lat mode    delay rdata     dw_base   dead  poke  err     status
        vecs[0] = '{16'h0C21, 0, 0, M_GOOD, 60,   16'h0800, 16'h0000, 1'b0, 1'b1, 3'b000, 16'h0800};
        vecs[1] = '{16'h0C23, 3, 5, M_GOOD, 10,   16'h0C00, 16'hA001, 1'b0, 1'b0, 3'b000, 16'h0C00};
        vecs[2] = '{16'h0C31, 1, 5, M_NONE, 0,    16'h0000, 16'hB001, 1'b0, 1'b0, 3'b001, 16'h0C00};
        vecs[3] = '{16'h0C42, 2, 0, M_BAD,  30,   16'h1234, 16'hC001, 1'b0, 1'b0, 3'b010, 16'h0C00};
        vecs[4] = '{16'h0C50, 0, 0, M_GOOD, TO,   16'h0555, 16'h0000, 1'b0, 1'b0, 3'b000, 16'h0555};
        vecs[5] = '{16'h0C62, 2, 0, M_NONE, 0,    16'h0000, 16'hE001, 1'b1, 1'b0, 3'b100, 16'h0555};
        vecs[6] = '{16'h0C71, 1, 2, M_GOOD, 15,   16'h0A5A, 16'hD001, 1'b0, 1'b0, 3'b000, 16'h0A5A};

        // Power-on reset
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        R = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 6; k++) run_msg(vecs[k]);

        // Reset asserted while waiting for a data word
        @(negedge clk);
        start = 1'b1;
        cw_in = 16'h0C22;
        n_dw  = 4'd2;
        @(negedge clk);
        start = 1'b0;
        chk("rst_seq_txen", {31'h0, txen}, 1);
        en_tx = 1'b1;
        repeat (8) @(negedge clk);
        en_tx = 1'b0;
        @(negedge clk);
        chk("rst_seq_dw_req", {31'h0, dw_req}, 1);
        R = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_in_fetch");
        R = 1'b0;
        @(negedge clk);

        // Fresh message accepted after the reset
        run_msg(vecs[6]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
